// File: rtl/acc_driver.sv
// acc_driver: gathers four signed samples into a vector, hands the vector to an
// accelerator, captures exactly one result per vector into a small FIFO and counts
// completed results.
// Optional feature: define ACC_DRIVER_TIMEOUT_EN to build the response watchdog,
// which abandons a stuck transaction and raises a sticky timeout_err.
module acc_driver #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              arst,
    input  logic signed [7:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [7:0] X1,
    output logic signed [7:0] X2,
    output logic signed [7:0] X3,
    output logic signed [7:0] X4,
    output logic              acc_valid,
    input  logic              acc_ready,
    input  logic signed [7:0] acc_y,
    input  logic              acc_valid_out,
    output logic              acc_ready_out,
    output logic signed [7:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic [15:0]       count,
    output logic              timeout_err
);

    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StLoad, StIssue, StWait} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [1:0]        r_idx;
    logic signed [7:0] r_lane [4];
    logic signed [7:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_occ;
    logic [15:0]       r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_load_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_timeout;

    assign w_full  = (r_occ == LP_DEPTH);
    assign w_empty = (r_occ == '0);
    assign w_pop   = res_ready && !w_empty;

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        acc_valid     = 1'b0;
        acc_ready_out = 1'b0;
        w_load_acc    = 1'b0;
        w_push        = 1'b0;
        unique case (r_state)
            StLoad: begin
                in_ready   = 1'b1;
                w_load_acc = in_valid;
                if (in_valid && (r_idx == 2'd3)) begin
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                acc_valid = 1'b1;
                if (acc_ready) begin
                    w_state_nxt = StWait;
                end else if (w_timeout) begin
                    w_state_nxt = StLoad;
                end
            end
            StWait: begin
                // A full FIFO back-pressures the accelerator so no result is lost
                acc_ready_out = !w_full;
                w_push        = acc_valid_out && !w_full;
                if (w_push || w_timeout) begin
                    w_state_nxt = StLoad;
                end
            end
            default: w_state_nxt = StLoad;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sample capture into the lane selected by idx; lanes frozen outside LOAD
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_idx <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_lane[i] <= '0;
            end
        end else if (w_load_acc) begin
            r_lane[r_idx] <= in_data;
            r_idx         <= r_idx + 2'd1;
        end
    end

    // Result FIFO storage, pointers, occupancy and completion counter
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= acc_y;
                r_wptr        <= r_wptr + 1'b1;
                r_count       <= r_count + 16'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

`ifdef ACC_DRIVER_TIMEOUT_EN
    logic [31:0] r_wd;
    logic        r_timeout_err;
    logic        w_wd_inc;

    // Count only while the driver is actually waiting on the accelerator
    assign w_wd_inc  = (r_state == StIssue) || ((r_state == StWait) && !w_full);
    assign w_timeout = w_wd_inc && ((r_wd + 32'd1) >= TIMEOUT_CYCLES);

    // Watchdog restarts on every state change; the error flag is sticky
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + 32'd1;
            end
            if (w_timeout && (w_state_nxt == StLoad) && !w_push) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign X1        = r_lane[0];
    assign X2        = r_lane[1];
    assign X3        = r_lane[2];
    assign X4        = r_lane[3];
    assign res_valid = !w_empty;
    assign res_data  = w_empty ? '0 : r_mem[r_rptr];
    assign count     = r_count;
    assign busy      = (r_state != StLoad) || (r_idx != 2'd0) || !w_empty;

endmodule

// File: tb/tb_acc_driver.sv
// tb_acc_driver: table-driven directed transactions, hand-written corner sequences
// (FIFO stall, simultaneous push/pop, mid-load reset, watchdog) and randomized
// transactions, all checked against a queue-based model of the result path.
module tb_acc_driver;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 64;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x1, x2, x3, x4;
    logic        acc_valid;
    logic        acc_ready;
    logic [7:0]  acc_y;
    logic        acc_valid_out;
    logic        acc_ready_out;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic [15:0] count;
    logic        timeout_err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q_m[$];
    logic [31:0] cnt_m;
    bit          rnd_pop;
    bit          last_push;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  y;
        int          lat;
        int          hold;
        logic [7:0]  exp_res;
        logic [15:0] exp_cnt;
    } vec_t;

    always #5 clk = ~clk;

    acc_driver #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .X1           (x1),
        .X2           (x2),
        .X3           (x3),
        .X4           (x4),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_y        (acc_y),
        .acc_valid_out(acc_valid_out),
        .acc_ready_out(acc_ready_out),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .count        (count),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare result-side outputs with the model, then advance both.
    task automatic tick(input bit wait_ph);
        bit         push;
        bit         pop;
        logic [7:0] y;
        if (rnd_pop) res_ready = ($urandom_range(0, 7) == 0);
        chk("res_valid", 32'(res_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) chk("res_data", 32'(res_data), 32'(q_m[0]));
        chk("count", 32'(count), 32'(cnt_m[15:0]));
        if (wait_ph) chk("acc_ready_out", 32'(acc_ready_out), 32'(q_m.size() < DEPTH));
        else         chk("acc_ready_out_idle", 32'(acc_ready_out), 32'd0);
        push = wait_ph && acc_valid_out && (q_m.size() < DEPTH);
        pop  = res_ready && (q_m.size() != 0);
        y    = acc_y;
        @(posedge clk);
        #1;
        if (pop) void'(q_m.pop_front());
        if (push) begin
            q_m.push_back(y);
            cnt_m++;
        end
        last_push = push;
    endtask

    task automatic do_reset();
        arst          = 1'b1;
        in_valid      = 1'b0;
        acc_ready     = 1'b0;
        acc_valid_out = 1'b0;
        res_ready     = 1'b0;
        rnd_pop       = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_acc_valid", 32'(acc_valid), 32'd0);
        chk("rst_acc_ready_out", 32'(acc_ready_out), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lanes", {x4, x3, x2, x1}, 32'd0);
        q_m.delete();
        cnt_m = 0;
        @(posedge clk);
        #3;
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input logic [31:0] v, input int gap_max);
        int g;
        for (int i = 0; i < 4; i++) begin
            g        = $urandom_range(0, gap_max);
            in_valid = 1'b0;
            repeat (g) begin
                chk("in_ready_load", 32'(in_ready), 32'd1);
                tick(1'b0);
            end
            in_valid = 1'b1;
            in_data  = v[8*i +: 8];
            chk("in_ready_load", 32'(in_ready), 32'd1);
            tick(1'b0);
        end
        in_valid = 1'b0;
    endtask

    // Holds the vector in ISSUE for dly cycles with junk on the sample input, then handshakes.
    task automatic issue_vec(input logic [31:0] v, input int dly);
        chk("x_lanes_issue", {x4, x3, x2, x1}, v);
        for (int i = 0; i <= dly; i++) begin
            acc_ready = (i == dly);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            chk("acc_valid_issue", 32'(acc_valid), 32'd1);
            chk("in_ready_issue", 32'(in_ready), 32'd0);
            tick(1'b0);
        end
        acc_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic finish_push(input logic [31:0] v, input logic [7:0] y, input int hold);
        int n;
        n             = 0;
        acc_valid_out = 1'b1;
        acc_y         = y;
        in_valid      = 1'b0;
        last_push     = 1'b0;
        chk("x_lanes_wait", {x4, x3, x2, x1}, v);
        while (!last_push && n < 300) begin
            tick(1'b1);
            n++;
        end
        chk("push_within_bound", 32'(last_push), 32'd1);
        repeat (hold) begin
            acc_y = 8'($urandom);
            tick(1'b0);
        end
        acc_valid_out = 1'b0;
    endtask

    task automatic respond(input logic [31:0] v, input logic [7:0] y, input int lat,
                           input int hold);
        for (int i = 0; i < lat; i++) begin
            acc_valid_out = 1'b0;
            acc_y         = 8'($urandom);
            in_valid      = 1'($urandom_range(0, 1));
            chk("acc_valid_wait", 32'(acc_valid), 32'd0);
            tick(1'b1);
        end
        in_valid = 1'b0;
        finish_push(v, y, hold);
    endtask

    task automatic drain(output int popped);
        rnd_pop   = 1'b0;
        res_ready = 1'b1;
        popped    = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (!res_valid) break;
            popped++;
            tick(1'b0);
        end
        res_ready = 1'b0;
        chk("drained", 32'(res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [4];
        logic [7:0]  ys [5];
        logic [31:0] v;
        int          popped;

        tbl[0] = '{v: 32'hD8_1E_EC_0A, y: 8'h55, lat: 3, hold: 0, exp_res: 8'h55, exp_cnt: 16'd1};
        tbl[1] = '{v: 32'h7F_80_01_FF, y: 8'hA3, lat: 0, hold: 2, exp_res: 8'hA3, exp_cnt: 16'd2};
        tbl[2] = '{v: 32'h12_34_56_78, y: 8'h80, lat: 5, hold: 1, exp_res: 8'h80, exp_cnt: 16'd3};
        tbl[3] = '{v: 32'h01_02_03_04, y: 8'h7F, lat: 1, hold: 0, exp_res: 8'h7F, exp_cnt: 16'd4};
        ys[0] = 8'h11; ys[1] = 8'h22; ys[2] = 8'h33; ys[3] = 8'h44; ys[4] = 8'h55;
        in_data = 8'h00;
        acc_y   = 8'h00;

        do_reset();

        // Directed transactions from the table
        for (int i = 0; i < 4; i++) begin
            load_vec(tbl[i].v, 0);
            issue_vec(tbl[i].v, 0);
            respond(tbl[i].v, tbl[i].y, tbl[i].lat, tbl[i].hold);
            chk("tbl_res_data", 32'(res_data), 32'(tbl[i].exp_res));
            chk("tbl_count", 32'(count), 32'(tbl[i].exp_cnt));
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            drain(popped);
            chk("tbl_pushes", 32'(popped), 32'd1);
        end

        // Five back-to-back transactions with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            load_vec(v, 0);
            issue_vec(v, 0);
            respond(v, ys[i], 1, 0);
        end
        chk("stall_count4", 32'(count), 32'd8);
        v = $urandom;
        load_vec(v, 0);
        issue_vec(v, 0);
        acc_valid_out = 1'b1;
        acc_y         = ys[4];
        repeat (3) tick(1'b1);
        chk("stall_ready", 32'(acc_ready_out), 32'd0);
        chk("stall_count5", 32'(count), 32'd8);
        chk("stall_head", 32'(res_data), 32'(ys[0]));
        chk("stall_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        finish_push(v, ys[4], 0);
        drain(popped);
        chk("stall_drain", 32'(popped), 32'd3);
        chk("stall_count_end", 32'(count), 32'd9);

        // Push and pop on the same edge at occupancy 2
        for (int i = 0; i < 2; i++) begin
            v = $urandom;
            load_vec(v, 0);
            issue_vec(v, 0);
            respond(v, 8'hC0 + 8'(i), 0, 0);
        end
        v = $urandom;
        load_vec(v, 0);
        issue_vec(v, 0);
        res_ready = 1'b1;
        finish_push(v, 8'h5A, 0);
        res_ready = 1'b0;
        chk("simul_head", 32'(res_data), 32'hC1);
        drain(popped);
        chk("simul_occupancy", 32'(popped), 32'd2);

        // Reset with a partial vector loaded and a result still queued
        v = $urandom;
        load_vec(v, 0);
        issue_vec(v, 0);
        respond(v, 8'h99, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'h33;
        tick(1'b0);
        in_data  = 8'h44;
        tick(1'b0);
        in_valid = 1'b0;
        chk("partial_busy", 32'(busy), 32'd1);
        chk("partial_lane0", 32'(x1), 32'h33);
        do_reset();
        v = 32'hA1_B2_C3_D4;
        load_vec(v, 0);
        issue_vec(v, 0);
        respond(v, 8'h3C, 2, 0);
        chk("fresh_count", 32'(count), 32'd1);
        drain(popped);

        // Randomized transactions against the model
        rnd_pop = 1'b1;
        for (int n = 0; n < 40; n++) begin
            v = $urandom;
            load_vec(v, 2);
            issue_vec(v, $urandom_range(0, 5));
            respond(v, 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 2));
        end
        drain(popped);
        chk("idle_busy", 32'(busy), 32'd0);

        // Accelerator never accepts the vector
        v = $urandom;
        load_vec(v, 0);
        acc_ready = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_issue", 32'(acc_valid), 32'd1);
            tick(1'b0);
        end
`ifdef ACC_DRIVER_TIMEOUT_EN
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_in_ready", 32'(in_ready), 32'd1);
        chk("tmo_acc_valid", 32'(acc_valid), 32'd0);
        chk("tmo_count", 32'(count), 32'(cnt_m[15:0]));
        chk("tmo_busy", 32'(busy), 32'd0);
        repeat (3) tick(1'b0);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
`else
        chk("tmo_err_off", 32'(timeout_err), 32'd0);
        chk("tmo_still_issue", 32'(in_ready), 32'd0);
        issue_vec(v, 0);
        respond(v, 8'h42, 0, 0);
        drain(popped);
        chk("tmo_late_result", 32'(popped), 32'd1);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_driver.md
ACC_DRIVER -- requirements
Module: acc_driver

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, result-FIFO entries (power of two, 2..16).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 64, accelerator response watchdog limit in cycles.
REQ-003 SHALL use clock clk; reset arst, asynchronous, active-high.
REQ-004 Ports, in order:
- clk, in, 1: clock.
- arst, in, 1: async reset.
- in_data, in, 8: signed input sample.
- in_valid, in, 1: sample valid.
- in_ready, out, 1: driver accepts a sample.
- X1, X2, X3, X4, out, 8 each: signed vector to the accelerator.
- acc_valid, out, 1: vector valid to the accelerator.
- acc_ready, in, 1: accelerator accepts the vector.
- acc_y, in, 8: signed accelerator result.
- acc_valid_out, in, 1: accelerator result valid.
- acc_ready_out, out, 1: driver accepts the result.
- res_data, out, 8: signed FIFO head.
- res_valid, out, 1: FIFO non-empty.
- res_ready, in, 1: consumer pops the head.
- busy, out, 1: transaction or data in flight.
- count, out, 16: completed-result counter.
- timeout_err, out, 1: sticky watchdog flag.

Function
REQ-005 SHALL implement an FSM with states LOAD, ISSUE and WAIT; reset state is LOAD.
REQ-006 LOAD behaviour:
- in_ready=1.
- Each in_valid&in_ready cycle stores in_data into lane idx (0→X1 … 3→X4) and increments the 2-bit idx.
- Acceptance at idx=3 wraps idx to 0; the next state is ISSUE.
REQ-007 ISSUE behaviour:
- acc_valid=1, in_ready=0.
- A cycle with acc_ready=1 is the vector handshake; the next state is WAIT and acc_valid drops.
REQ-008 WAIT behaviour:
- acc_ready_out = NOT fifo_full.
- The first cycle with acc_valid_out&acc_ready_out pushes acc_y into the FIFO and increments count; the next state is LOAD.
- acc_valid_out seen outside WAIT SHALL be ignored, so the driver captures exactly one result per vector.
REQ-009 X1..X4 SHALL hold stable from ISSUE entry until return to LOAD; acc_valid and acc_ready_out are registered-state decodes and never glitch to 1 outside ISSUE/WAIT.
REQ-010 The FIFO SHALL be first-in first-out:
- res_data = head; res_valid = NOT empty.
- Pop on res_valid&res_ready.
- A simultaneous push and pop leaves occupancy unchanged.
- A pop when empty is ignored.
REQ-011 When the FIFO is full, acc_ready_out=0 and the driver stalls in WAIT; no result is dropped or overwritten.
REQ-012 count SHALL wrap 0xFFFF→0x0000.
REQ-013 busy = (state≠LOAD) OR (idx≠0) OR res_valid.
REQ-014 in_valid in ISSUE/WAIT SHALL have no effect; the upstream source holds its data.

Reset
REQ-015 arst SHALL immediately force all of the following, including mid-transaction:
- state=LOAD, idx=0.
- X1..X4=0, acc_valid=0, acc_ready_out=0.
- FIFO empty, res_valid=0, res_data=0.
- count=0, timeout_err=0, busy=0.
- in_ready=1.
REQ-016 A partially loaded vector or in-flight result SHALL be discarded by reset.

Configuration
REQ-017 Macro ACC_DRIVER_TIMEOUT_EN defined, watchdog behaviour:
- A cycle counter clears on ISSUE entry and on the vector handshake, and increments every cycle in ISSUE and in WAIT while acc_ready_out=1.
- On reaching TIMEOUT_CYCLES, timeout_err is set (sticky until arst), the vector is abandoned with no FIFO push and no count increment, and the state returns to LOAD.
REQ-018 Macro undefined: no watchdog logic, timeout_err tied 0, and the driver waits indefinitely.

Verification
REQ-019 Bench SHALL cover:
- Samples 10,-20,30,-40 with acc_ready=1 and acc_y=0x55 after 3 cycles -> X1..X4=10,-20,30,-40 in ISSUE; res_data=0x55, res_valid=1, count=1.
- acc_valid_out held high for 3 cycles in WAIT -> exactly one FIFO push, count +1.
- res_ready=0, five back-to-back transactions -> 4 results queued; 5th stalls with acc_ready_out=0; releasing res_ready pops in order; 5th completes.
- Simultaneous pop and push at occupancy 2 -> occupancy stays 2, order preserved.
- arst asserted after 2 samples loaded -> idx=0, X1..X4=0, in_ready=1; next 4 samples form a fresh vector.
- With ACC_DRIVER_TIMEOUT_EN, acc_ready=0 for 64 cycles -> timeout_err=1, state LOAD, count unchanged; without the macro -> still ISSUE, timeout_err=0.
